instruction_encoder: RTL and testbench

- Inverse of the instruction field parser. Accepts decoded instruction fields over a valid/ready handshake and packs them into INSTRUCTION_WIDTH words.
- Writes the packed words sequentially into program memory, starting at a base address.
- Used by the loader/test harness to build programs for the CPU. Sits between the field source and the program-memory write port.

---
 rtl/puc_isa_pkg.sv | 41 ++++
 rtl/instruction_pack.sv | 49 ++++
 rtl/instruction_encoder.sv | 122 ++++++++++++
 tb/tb_instruction_encoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puc_isa_pkg.sv
// Shared ISA definitions for the instruction word: field widths, field positions, addressing types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Upper fields are placed relative to the MSB, so they follow the instruction width.
// The low fields (output register flag and types) are fixed at the bottom of the word.
package puc_isa_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam int VALUE_WIDTH  = 8;
    localparam int ADDR_WIDTH   = 8;
    localparam int TYPE_WIDTH   = 2;
    localparam int REG_SEL_WIDTH = 3;

    // Each offset is the distance from the word MSB (W-1) to the field's top bit, plus one.
    localparam int FLAG_IN1_OFS = 1;
    localparam int FLAG_IN2_OFS = 2;
    localparam int OPCODE_OFS   = 3;
    localparam int ADDR1_OFS    = 9;
    localparam int ADDR2_OFS    = 17;
    localparam int ADDR_OUT_OFS = 25;

    // Absolute positions of the fields at the bottom of the word.
    localparam int FLAG_OUT_POS = 6;
    localparam int TYPE1_LSB    = 4;
    localparam int TYPE2_LSB    = 2;
    localparam int TYPE_OUT_LSB = 0;

    typedef enum logic [TYPE_WIDTH-1:0] {
        ATYPE_ABS = 2'd0,
        ATYPE_IND = 2'd1,
        ATYPE_REG = 2'd2,
        ATYPE_IMM = 2'd3
    } addr_type_e;

    // A register operand only carries a register index in the low bits of its address field.
    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic is_reg);
        return is_reg ? {{(ADDR_WIDTH-REG_SEL_WIDTH){1'b0}}, addr[REG_SEL_WIDTH-1:0]} : addr;
    endfunction

endpackage

// File: rtl/instruction_pack.sv
// Packs one set of decoded instruction fields into an instruction word.
// Latency: purely combinational. Backpressure: none; the word follows the inputs.
// Ports: field inputs (*_i) -> word_o. INSTRUCTION_WIDTH must be at least 39.
module instruction_pack
    import puc_isa_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 40
) (
    input  logic [OPCODE_WIDTH-1:0]      op_code_i,
    input  logic [ADDR_WIDTH-1:0]        addr1_i,
    input  logic [ADDR_WIDTH-1:0]        addr2_i,
    input  logic [ADDR_WIDTH-1:0]        addr_out_i,
    input  addr_type_e                   type1_i,
    input  addr_type_e                   type2_i,
    input  addr_type_e                   type_out_i,
    input  logic [2:0]                   reg_flags_i,
    input  logic                         use_value_i,
    input  logic [VALUE_WIDTH-1:0]       value_i,
    output logic [INSTRUCTION_WIDTH-1:0] word_o
);

    localparam int W = INSTRUCTION_WIDTH;

    logic                  flag_in2;
    logic [ADDR_WIDTH-1:0] a1_fld;
    logic [ADDR_WIDTH-1:0] a2_fld;
    logic [ADDR_WIDTH-1:0] ao_fld;

    always_comb begin
        // The immediate occupies the addr2 field, so that operand can no longer be a register.
        flag_in2 = reg_flags_i[1] & ~use_value_i;
        a1_fld   = reg_addr(addr1_i, reg_flags_i[2]);
        a2_fld   = use_value_i ? value_i : reg_addr(addr2_i, reg_flags_i[1]);
        ao_fld   = reg_addr(addr_out_i, reg_flags_i[0]);

        word_o = '0;
        word_o[W-FLAG_IN1_OFS]                  = reg_flags_i[2];
        word_o[W-FLAG_IN2_OFS]                  = flag_in2;
        word_o[W-OPCODE_OFS -: OPCODE_WIDTH]    = op_code_i;
        word_o[W-ADDR1_OFS -: ADDR_WIDTH]       = a1_fld;
        word_o[W-ADDR2_OFS -: ADDR_WIDTH]       = a2_fld;
        word_o[W-ADDR_OUT_OFS -: ADDR_WIDTH]    = ao_fld;
        word_o[FLAG_OUT_POS]                    = reg_flags_i[0];
        word_o[TYPE1_LSB +: TYPE_WIDTH]         = type1_i;
        word_o[TYPE2_LSB +: TYPE_WIDTH]         = type2_i;
        word_o[TYPE_OUT_LSB +: TYPE_WIDTH]      = type_out_i;
    end

endmodule

// File: rtl/instruction_encoder.sv
// Loads a program: packs field sets and writes them to consecutive program-memory addresses.
// Latency: one cycle from accept to mem_we. Backpressure: in_ready only in RUN and not during start.
// Ports: start/base_addr open a session; in_* handshake carries field sets; mem_* is the write
// port; busy/done/overflow/word_count report session status.
module instruction_encoder
    import puc_isa_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 40,
    parameter int PROG_ADDR_WIDTH   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PROG_ADDR_WIDTH-1:0]   base_addr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [OPCODE_WIDTH-1:0]      op_code,
    input  logic [ADDR_WIDTH-1:0]        addr1,
    input  logic [ADDR_WIDTH-1:0]        addr2,
    input  logic [ADDR_WIDTH-1:0]        addr_out,
    input  logic [TYPE_WIDTH-1:0]        type1,
    input  logic [TYPE_WIDTH-1:0]        type2,
    input  logic [TYPE_WIDTH-1:0]        type_out,
    input  logic [2:0]                   reg_flags,
    input  logic                         use_value,
    input  logic [VALUE_WIDTH-1:0]       value,
    output logic                         mem_we,
    output logic [PROG_ADDR_WIDTH-1:0]   mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [PROG_ADDR_WIDTH:0]     word_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    state_e                         state_q;
    logic [PROG_ADDR_WIDTH-1:0]     ptr_q;
    logic [PROG_ADDR_WIDTH:0]       count_q;
    logic                           overflow_q;
    logic                           we_q;
    logic [PROG_ADDR_WIDTH-1:0]     addr_q;
    logic [INSTRUCTION_WIDTH-1:0]   wdata_q;
    logic [INSTRUCTION_WIDTH-1:0]   word_d;
    logic                           accept;

    instruction_pack #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
    ) u_pack (
        .op_code_i   (op_code),
        .addr1_i     (addr1),
        .addr2_i     (addr2),
        .addr_out_i  (addr_out),
        .type1_i     (addr_type_e'(type1)),
        .type2_i     (addr_type_e'(type2)),
        .type_out_i  (addr_type_e'(type_out)),
        .reg_flags_i (reg_flags),
        .use_value_i (use_value),
        .value_i     (value),
        .word_o      (word_d)
    );

    // Holding off input while start is high means a restart never swallows a field set.
    assign in_ready = (state_q == S_RUN) && !start;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_ERROR, S_RUN: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        ptr_q      <= base_addr;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end else if (accept) begin
                        we_q    <= 1'b1;
                        addr_q  <= ptr_q;
                        wdata_q <= word_d;
                        ptr_q   <= ptr_q + 1'b1;
                        count_q <= count_q + 1'b1;
                        if (in_last) begin
                            state_q <= S_DONE;
                        end else if (ptr_q == '1) begin
                            // Top of memory reached with more to come: stop rather than wrap.
                            state_q    <= S_ERROR;
                            overflow_q <= 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // DONE is entered on the final accept, so it coincides with the final write.
    assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign overflow   = overflow_q;
    assign word_count = count_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed sessions plus randomized sessions
// checked against a word/address model built from the field layout with plain shifts.
// All DUT outputs are sampled on the falling clock edge; inputs change 1 time unit after rising.
module tb_instruction_encoder;

    localparam int W  = 40;
    localparam int AW = 8;

    typedef struct {
        logic [5:0] op;
        logic [7:0] a1, a2, ao;
        logic [1:0] t1, t2, to;
        logic [2:0] fl;
        logic       uv;
        logic [7:0] val;
    } fset_t;

    logic          clock, reset, start, in_valid, in_ready, in_last, use_value;
    logic [AW-1:0] base_addr, mem_addr;
    logic [5:0]    op_code;
    logic [7:0]    addr1, addr2, addr_out, value;
    logic [1:0]    type1, type2, type_out;
    logic [2:0]    reg_flags;
    logic          mem_we, busy, done, overflow;
    logic [W-1:0]  mem_wdata;
    logic [AW:0]   word_count;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int done_misaligned = 0;

    logic [AW-1:0] got_addr[$], exp_addr[$];
    logic [W-1:0]  got_data[$], exp_data[$];

    instruction_encoder #(.INSTRUCTION_WIDTH(W), .PROG_ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op_code(op_code), .addr1(addr1), .addr2(addr2), .addr_out(addr_out),
        .type1(type1), .type2(type2), .type_out(type_out),
        .reg_flags(reg_flags), .use_value(use_value), .value(value),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write monitor.
    always @(negedge clock) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
        if (done) done_seen++;
        if (done && !mem_we) done_misaligned++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference packing straight from the field layout.
    function automatic logic [W-1:0] model_word(input fset_t f);
        logic [63:0] w;
        logic [7:0]  e1, e2, eo;
        logic        fin2;
        e1   = f.fl[2] ? (f.a1 % 8'd8) : f.a1;
        e2   = f.uv ? f.val : (f.fl[1] ? (f.a2 % 8'd8) : f.a2);
        eo   = f.fl[0] ? (f.ao % 8'd8) : f.ao;
        fin2 = f.fl[1] && !f.uv;
        w = 64'(f.fl[2]) << (W-1);
        w = w | (64'(fin2) << (W-2));
        w = w | (64'(f.op) << (W-8));
        w = w | (64'(e1) << (W-16));
        w = w | (64'(e2) << (W-24));
        w = w | (64'(eo) << (W-32));
        w = w | (64'(f.fl[0]) << 6);
        w = w | (64'(f.t1) << 4) | (64'(f.t2) << 2) | 64'(f.to);
        return w[W-1:0];
    endfunction

    function automatic fset_t rand_fset();
        fset_t f;
        f.op  = 6'($urandom);
        f.a1  = 8'($urandom);
        f.a2  = 8'($urandom);
        f.ao  = 8'($urandom);
        f.t1  = 2'($urandom);
        f.t2  = 2'($urandom);
        f.to  = 2'($urandom);
        f.fl  = 3'($urandom);
        f.uv  = ($urandom_range(0, 3) == 0);
        f.val = 8'($urandom);
        return f;
    endfunction

    function automatic fset_t mk(input logic [5:0] op, input logic [7:0] a1, input logic [7:0] a2,
                                 input logic [7:0] ao, input logic [1:0] t1, input logic [1:0] t2,
                                 input logic [1:0] to, input logic [2:0] fl, input logic uv,
                                 input logic [7:0] val);
        fset_t f;
        f.op = op; f.a1 = a1; f.a2 = a2; f.ao = ao; f.t1 = t1; f.t2 = t2; f.to = to;
        f.fl = fl; f.uv = uv; f.val = val;
        return f;
    endfunction

    task automatic apply(input fset_t f);
        op_code = f.op; addr1 = f.a1; addr2 = f.a2; addr_out = f.ao;
        type1 = f.t1; type2 = f.t2; type_out = f.to;
        reg_flags = f.fl; use_value = f.uv; value = f.val;
    endtask

    // Called 1 unit after a rising edge; returns 1 unit after the edge that accepted.
    task automatic send(input fset_t f, input logic last, output bit ok);
        apply(f);
        in_last = last;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 16 && !ok; c++) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        start = 1'b1;
        base_addr = b;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check({tag, "_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
            check({tag, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
        end
    endtask

    // Directed single-word session with fixed expected word.
    task automatic one_word(input string tag, input fset_t f, input logic [W-1:0] exp_word);
        bit ok;
        pulse_start(8'h10);
        send(f, 1'b1, ok);
        check({tag, "_accept"}, 64'(ok), 64'd1);
        @(negedge clock);
        check({tag, "_we"}, 64'(mem_we), 64'd1);
        check({tag, "_addr"}, 64'(mem_addr), 64'h10);
        check({tag, "_data"}, 64'(mem_wdata), 64'(exp_word));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_count"}, 64'(word_count), 64'd1);
        @(negedge clock);
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        fset_t fa, fb, fc;
        bit ok;

        reset = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        apply(mk(6'h0, 8'h0, 8'h0, 8'h0, 2'd0, 2'd0, 2'd0, 3'b000, 1'b0, 8'h0));
        #1 reset = 1'b1;
        #1;
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Packing cases with known words.
        one_word("plain", mk(6'h05, 8'h12, 8'h34, 8'h56, 2'd1, 2'd2, 2'd3, 3'b000, 1'b0, 8'h00),
                 40'h051234561B);
        one_word("regs", mk(6'h3F, 8'hFB, 8'h0A, 8'h0F, 2'd0, 2'd0, 2'd0, 3'b111, 1'b0, 8'h00),
                 40'hFF03020740);
        one_word("imm", mk(6'h05, 8'h12, 8'h34, 8'h56, 2'd1, 2'd2, 2'd3, 3'b010, 1'b1, 8'hAB),
                 40'h0512AB561B);

        // Overflow: back-to-back sets from 0xFE, none marked last.
        fa = rand_fset(); fb = rand_fset(); fc = rand_fset();
        pulse_start(8'hFE);
        apply(fa); in_valid = 1'b1; in_last = 1'b0;
        @(negedge clock);
        check("ovf_ready_a", 64'(in_ready), 64'd1);
        @(posedge clock); #1 apply(fb);
        @(negedge clock);
        check("ovf_addr_a", 64'(mem_addr), 64'hFE);
        check("ovf_ready_b", 64'(in_ready), 64'd1);
        @(posedge clock); #1 apply(fc);
        @(negedge clock);
        check("ovf_ready_c", 64'(in_ready), 64'd0);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_busy", 64'(busy), 64'd0);
        @(posedge clock); #1 in_valid = 1'b0;
        @(posedge clock); #1;
        exp_addr.push_back(8'hFE); exp_data.push_back(model_word(fa));
        exp_addr.push_back(8'hFF); exp_data.push_back(model_word(fb));
        compare_writes("ovf");
        check("ovf_count", 64'(word_count), 64'd2);
        check("ovf_done", 64'(done_seen), 64'd3);

        // Restart in RUN while a write is still pending and a new set is waiting.
        fa = rand_fset(); fb = rand_fset();
        pulse_start(8'h40);
        check("rs_clear_ovf", 64'(overflow), 64'd0);
        send(fa, 1'b0, ok);
        check("rs_accept_a", 64'(ok), 64'd1);
        start = 1'b1; base_addr = 8'h80; apply(fb); in_valid = 1'b1; in_last = 1'b1;
        @(negedge clock);
        check("rs_ready_low", 64'(in_ready), 64'd0);
        check("rs_pending_we", 64'(mem_we), 64'd1);
        check("rs_pending_addr", 64'(mem_addr), 64'h40);
        check("rs_pending_data", 64'(mem_wdata), 64'(model_word(fa)));
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        check("rs_count_clr", 64'(word_count), 64'd0);
        check("rs_ready_high", 64'(in_ready), 64'd1);
        @(posedge clock); #1 in_valid = 1'b0; in_last = 1'b0;
        @(negedge clock);
        check("rs_b_we", 64'(mem_we), 64'd1);
        check("rs_b_addr", 64'(mem_addr), 64'h80);
        check("rs_b_data", 64'(mem_wdata), 64'(model_word(fb)));
        check("rs_b_count", 64'(word_count), 64'd1);
        @(posedge clock); #1;

        // Randomized sessions with idle gaps, some starting near the top of memory.
        for (int s = 0; s < 14; s++) begin
            logic [AW-1:0] base;
            int len, ptr, acc, gap, d0;
            bit last_sent, ovf_exp, lastb;
            base = (s % 3 == 0) ? 8'(8'hF8 + 8'($urandom_range(0, 7))) : 8'($urandom);
            len = $urandom_range(1, 8);
            pulse_start(base);
            d0 = done_seen;
            ptr = int'(base); acc = 0; last_sent = 1'b0; ovf_exp = 1'b0;
            for (int i = 0; i < len; i++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin @(posedge clock); #1; end
                fa = rand_fset();
                lastb = (i == len - 1);
                send(fa, lastb, ok);
                check("rnd_accept", 64'(ok), 64'd1);
                if (!ok) break;
                exp_addr.push_back(8'(ptr));
                exp_data.push_back(model_word(fa));
                acc++;
                if (lastb) last_sent = 1'b1;
                else if (ptr == 255) begin ovf_exp = 1'b1; break; end
                ptr++;
            end
            repeat (2) begin @(posedge clock); #1; end
            compare_writes("rnd");
            check("rnd_done", 64'(done_seen - d0), 64'(last_sent));
            check("rnd_overflow", 64'(overflow), 64'(ovf_exp));
            check("rnd_count", 64'(word_count), 64'(acc));
            check("rnd_busy", 64'(busy), 64'd0);
        end

        // Reset right after an accept: the registered write must never appear.
        pulse_start(8'h20);
        apply(rand_fset()); in_valid = 1'b1; in_last = 1'b1;
        @(negedge clock);
        check("ar_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1 reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        #1;
        check("ar_we", 64'(mem_we), 64'd0);
        check("ar_addr", 64'(mem_addr), 64'd0);
        check("ar_wdata", 64'(mem_wdata), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_done", 64'(done), 64'd0);
        check("ar_count", 64'(word_count), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("ar_no_write", 64'(got_addr.size()), 64'd0);
        check("done_with_we", 64'(done_misaligned), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
